// File: rtl/rv_pkg.sv
// Shared register-file definitions: widths, the hard-wired zero register and
// the write-request record used by the write queue and the register file.
package rv_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // Register x0 reads as zero, so writes to it are dropped.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// Circular write-request store for the register-file write queue.
// Occupancy comes from an explicit counter, so the pointers only need to wrap.
// Per-entry valid/address vectors are exported for the pending-write compare.
module rf_wq_fifo
  import rv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [DATA_W-1:0]       head_data,
  output logic [CW-1:0]           count,
  output logic [DEPTH-1:0]        ent_valid,
  output logic [DEPTH*ADDR_W-1:0] ent_addr
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     offset;

  // Pointer and occupancy bookkeeping; flush empties the queue at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; only entries inside the occupancy window are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // An entry is live when its distance ahead of the read pointer is below the count.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, offset} < count);
      ent_addr[i*ADDR_W +: ADDR_W] = addr_mem[i];
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// Buffered write-side driver for the register file: accepts writes over a
// valid/ready handshake, drains at most one per cycle onto wa3/wd3/we3, drops
// writes to x0, and flags pending writes for two read addresses.
module rf_write_queue
  import rv_pkg::*;
#(
  parameter int DATA_W = rv_pkg::DATA_W,
  parameter int ADDR_W = rv_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  input  logic                   drain_en,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      wa3,
  output logic [DATA_W-1:0]      wd3,
  output logic                   we3,
  input  logic [ADDR_W-1:0]      chk_a1,
  input  logic [ADDR_W-1:0]      chk_a2,
  output logic                   pend1,
  output logic                   pend2,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic                    accept;
  logic                    is_x0;
  logic                    push;
  logic                    pop;
  logic [ADDR_W-1:0]       head_addr;
  logic [DATA_W-1:0]       head_data;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH*ADDR_W-1:0] ent_addr;

  // Ready ignores any same-cycle pop so a full queue always stalls one cycle.
  assign req_ready = (count != FULL_CNT) && !flush;
  assign accept    = req_valid && req_ready;
  assign is_x0     = (req_addr == ZERO_ADDR);
  assign push      = accept && !is_x0;
  assign pop       = (count != '0) && drain_en && !flush;

  rf_wq_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (req_addr),
    .push_data (req_data),
    .pop       (pop),
    .flush     (flush),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // Register-file write port: pulse we3 on each pop, hold address/data otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (pop) begin
      we3 <= 1'b1;
      wa3 <= head_addr;
      wd3 <= head_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Saturating count of x0 writes that were consumed and thrown away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (accept && is_x0 && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Pending when a live entry or the in-flight write targets the checked register.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i*ADDR_W +: ADDR_W] == chk_a1)) pend1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i*ADDR_W +: ADDR_W] == chk_a2)) pend2 = 1'b1;
    end
    if (we3 && (wa3 == chk_a1)) pend1 = 1'b1;
    if (we3 && (wa3 == chk_a2)) pend2 = 1'b1;
    if (chk_a1 == ZERO_ADDR) pend1 = 1'b0;
    if (chk_a2 == ZERO_ADDR) pend2 = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: a vector table for the fill/stall
// phase, hand sequences for latency, x0 drops, flush, streaming and reset,
// and a scoreboard that checks every we3 pulse against accepted writes.
module tb_rf_write_queue;
  import rv_pkg::*;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       drain_en;
  logic       flush;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic       we3;
  logic [2:0] chk_a1;
  logic [2:0] chk_a2;
  logic       pend1;
  logic       pend2;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: expected occupancy and the writes still owed to the register file.
  int      m_count;
  wr_req_t sb_q[$];

  typedef struct {
    logic       valid;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] c1;
    logic [2:0] c2;
    logic       exp_ready;
    int         exp_count;
    logic       exp_p1;
    logic       exp_p2;
  } vec_t;

  vec_t vecs[6];

  rf_write_queue #(
    .DATA_W (8),
    .ADDR_W (3),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .drain_en  (drain_en),
    .flush     (flush),
    .wa3       (wa3),
    .wd3       (wd3),
    .we3       (we3),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .pend1     (pend1),
    .pend2     (pend2),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] a, input logic [7:0] d,
                                input logic dr, input logic fl);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    drain_en  = dr;
    flush     = fl;
  endtask

  // Transaction-level model: decides acceptance/pops from its own count and queues expected writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0;
      sb_q.delete();
    end else if (flush) begin
      m_count = 0;
      sb_q.delete();
    end else begin
      automatic bit m_pop = (m_count != 0) && drain_en;
      automatic bit m_acc = req_valid && (m_count != 4);
      automatic bit m_push = m_acc && (req_addr != 3'd0);
      if (m_push) sb_q.push_back('{addr: req_addr, data: req_data});
      m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // Every register-file write must match the oldest outstanding accepted write.
  always @(negedge clk) begin
    if (rst && we3) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL sb_unexpected_we3: got wa3=%0d wd3=%0h, required no write", wa3, wd3);
      end else begin
        automatic wr_req_t e = sb_q.pop_front();
        check_output("sb_wa3", int'(wa3), int'(e.addr));
        check_output("sb_wd3", int'(wd3), int'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_d[4];
    logic [2:0] exp_a[4];

    vecs[0] = '{1'b1, 3'd1, 8'h11, 3'd1, 3'd2, 1'b1, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 8'h22, 3'd1, 3'd2, 1'b1, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 3'd1, 8'h33, 3'd1, 3'd4, 1'b1, 2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd4, 8'h44, 3'd4, 3'd2, 1'b1, 3, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 3'd5, 8'h55, 3'd4, 3'd5, 1'b0, 4, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 3'd5, 8'h55, 3'd0, 3'd3, 1'b0, 4, 1'b0, 1'b0};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_a = '{3'd1, 3'd2, 3'd1, 3'd4};

    rst = 1'b0;
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk_a1 = 3'd1;
    chk_a2 = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ready", int'(req_ready), 1);
    check_output("rst_count", int'(count), 0);
    check_output("rst_we3", int'(we3), 0);
    check_output("rst_drop", int'(drop_cnt), 0);
    check_output("rst_pend", int'({pend1, pend2}), 0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Single write latency: accepted at N, we3 during N+1..N+2.
    $display("[TB] single write latency");
    apply_stimulus(1'b1, 3'd3, 8'hA5, 1'b1, 1'b0);
    chk_a1 = 3'd3;
    chk_a2 = 3'd0;
    #1;
    check_output("lat_ready", int'(req_ready), 1);
    check_output("lat_pend_before", int'(pend1), 0);
    cycle();
    req_valid = 1'b0;
    #1;
    check_output("lat_count_n", int'(count), 1);
    check_output("lat_we3_n", int'(we3), 0);
    check_output("lat_pend_queued", int'(pend1), 1);
    cycle();
    check_output("lat_we3_n1", int'(we3), 1);
    check_output("lat_wa3_n1", int'(wa3), 3);
    check_output("lat_wd3_n1", int'(wd3), 8'hA5);
    check_output("lat_pend_inflight", int'(pend1), 1);
    check_output("lat_pend_x0", int'(pend2), 0);
    cycle();
    check_output("lat_we3_n2", int'(we3), 0);
    check_output("lat_pend_after", int'(pend1), 0);

    // Fill with drain held off, then stall a fifth request.
    $display("[TB] fill and stall table");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].addr, vecs[i].data, 1'b0, 1'b0);
      chk_a1 = vecs[i].c1;
      chk_a2 = vecs[i].c2;
      #1;
      check_output($sformatf("vec%0d_ready", i), int'(req_ready), int'(vecs[i].exp_ready));
      check_output($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      check_output($sformatf("vec%0d_pend1", i), int'(pend1), int'(vecs[i].exp_p1));
      check_output($sformatf("vec%0d_pend2", i), int'(pend2), int'(vecs[i].exp_p2));
      cycle();
    end
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    #1;
    check_output("drain_start_count", int'(count), 4);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_output($sformatf("drain%0d_we3", k), int'(we3), 1);
      check_output($sformatf("drain%0d_wa3", k), int'(wa3), int'(exp_a[k]));
      check_output($sformatf("drain%0d_wd3", k), int'(wd3), int'(exp_d[k]));
      check_output($sformatf("drain%0d_count", k), int'(count), 3 - k);
    end
    cycle();
    check_output("drain_done_we3", int'(we3), 0);

    // Writes to x0 are consumed without being stored.
    $display("[TB] x0 drop");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 3'd0, 8'hEE, 1'b1, 1'b0);
      #1;
      check_output($sformatf("x0_%0d_ready", k), int'(req_ready), 1);
      check_output($sformatf("x0_%0d_count", k), int'(count), 0);
      check_output($sformatf("x0_%0d_we3", k), int'(we3), 0);
      cycle();
    end
    req_valid = 1'b0;
    #1;
    check_output("x0_drop3", int'(drop_cnt), 3);
    check_output("x0_count", int'(count), 0);
    req_valid = 1'b1;
    repeat (300) cycle();
    req_valid = 1'b0;
    #1;
    check_output("x0_drop_sat", int'(drop_cnt), 255);

    // Flush with a simultaneous request.
    $display("[TB] flush");
    apply_stimulus(1'b1, 3'd6, 8'h66, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 3'd7, 8'h77, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 3'd2, 8'h99, 1'b0, 1'b1);
    chk_a1 = 3'd6;
    chk_a2 = 3'd7;
    #1;
    check_output("fl_ready", int'(req_ready), 0);
    check_output("fl_count_before", int'(count), 2);
    check_output("fl_pend_before", int'({pend1, pend2}), 3);
    cycle();
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    #1;
    check_output("fl_count", int'(count), 0);
    check_output("fl_we3", int'(we3), 0);
    check_output("fl_pend", int'({pend1, pend2}), 0);
    check_output("fl_drop_kept", int'(drop_cnt), 255);
    chk_a1 = 3'd2;
    cycle();
    check_output("fl_req_dropped_we3", int'(we3), 0);
    check_output("fl_req_dropped_pend", int'(pend1), 0);
    check_output("fl_req_dropped_count", int'(count), 0);

    // Streaming push and pop at occupancy 2 with pointer wrap.
    $display("[TB] streaming");
    apply_stimulus(1'b1, 3'd1, 8'h10, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 3'd2, 8'h20, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 3'((i % 7) + 1), 8'h30 + 8'(i), 1'b1, 1'b0);
      #1;
      check_output($sformatf("str%0d_count", i), int'(count), 2);
      check_output($sformatf("str%0d_we3", i), int'(we3), (i != 0) ? 1 : 0);
      cycle();
    end
    check_output("str_end_count", int'(count), 2);
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    repeat (3) cycle();
    check_output("str_drained_count", int'(count), 0);
    check_output("str_sb_empty", sb_q.size(), 0);

    // Asynchronous reset while a write is in flight.
    $display("[TB] async reset");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 3'(i + 1), 8'hC0 + 8'(i), 1'b0, 1'b0);
      cycle();
    end
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    chk_a1 = 3'd2;
    chk_a2 = 3'd3;
    cycle();
    check_output("ar_pre_we3", int'(we3), 1);
    check_output("ar_pre_count", int'(count), 3);
    #2;
    rst = 1'b0;
    #1;
    check_output("ar_we3", int'(we3), 0);
    check_output("ar_wa3", int'(wa3), 0);
    check_output("ar_wd3", int'(wd3), 0);
    check_output("ar_count", int'(count), 0);
    check_output("ar_drop", int'(drop_cnt), 0);
    check_output("ar_ready", int'(req_ready), 1);
    check_output("ar_pend", int'({pend1, pend2}), 0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    check_output("ar_post_we3", int'(we3), 0);
    check_output("ar_post_count", int'(count), 0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
# rf_write_queue

Buffered write-side driver for the 8×8-bit register file. Execution-side producers hand register writes to this block over a valid/ready handshake. The block queues them in a small FIFO and drains at most one per cycle onto the register file's `wd3`/`wa3`/`we3` port. It also reports, for two register addresses, whether a write to that register is still pending, so the read side can stall instead of reading stale data.

## Interface
- `DATA_W`, 8, register data width
- `ADDR_W`, 3, register address width (8 registers, x0 hard-wired zero)
- `DEPTH`, 4, queue entries (power of two)
- `clk` in 1, rising-edge clock
- `rst` in 1, reset, asynchronous, active-low
- `req_valid` in 1, producer offers a write
- `req_ready` out 1, block can accept this cycle
- `req_addr` in ADDR_W, destination register
- `req_data` in DATA_W, value to write
- `drain_en` in 1, 1 = allow a pop this cycle; 0 = hold the queue (single-step/debug)
- `flush` in 1, synchronous discard of all queued writes
- `wa3` out ADDR_W, register file write address (registered)
- `wd3` out DATA_W, register file write data (registered)
- `we3` out 1, register file write enable (registered)
- `chk_a1`, `chk_a2` in ADDR_W, addresses to check for pending writes
- `pend1`, `pend2` out 1, a write to `chk_a1`/`chk_a2` is queued or in flight
- `count` out $clog2(DEPTH)+1, current occupancy, 0..DEPTH
- `drop_cnt` out 8, number of writes to x0 discarded, saturating

## Operation
- Accept:
  - A transfer occurs when `req_valid && req_ready`.
  - `req_ready = (count != DEPTH) && !flush`. It does not depend on a same-cycle pop, so a full queue accepts nothing.
- x0 writes:
  - An accepted request with `req_addr == 0` is consumed but not stored.
  - `count` is unchanged and `drop_cnt` increments, saturating at 255.
- Pop:
  - A pop occurs when `count != 0 && drain_en && !flush`.
  - On a pop, at that edge: `we3 <= 1`, `wa3 <= head.addr`, `wd3 <= head.data`, and the read pointer advances.
  - With no pop: `we3 <= 0`, while `wa3`/`wd3` hold their last values.
- Simultaneous push and pop, with the queue not full: `count` is unchanged and the entries stay in FIFO order.
- Pointers wrap modulo DEPTH. Occupancy is tracked by `count`, not by pointer comparison.
- Flush:
  - At the edge: `count <= 0`, both pointers `<= 0`, `we3 <= 0`.
  - A request presented in the same cycle is not accepted, because `req_ready` is 0.
  - `drop_cnt` is not cleared.
- Pending check (combinational):
  - `pendN = 1` iff `chk_aN != 0` and either a valid queue entry has `addr == chk_aN`, or `we3 && wa3 == chk_aN`.
  - The in-flight write counts as pending because the register file has not captured it yet.
- Ordering: multiple queued writes to the same register are drained in arrival order. No coalescing.

## Timing
- Reset (`rst` low, asynchronous): `count=0`, pointers 0, `we3=0`, `wa3=0`, `wd3=0`, `drop_cnt=0`. Storage contents are don't-care.
  - Consequently `req_ready=1`, `pend1=pend2=0`.
  - Reset asserted mid-operation discards all queued and in-flight writes immediately.
- Latency, empty queue with `drain_en=1`:
  - Request accepted at edge N → `count=1` after N.
  - Pop at edge N+1 → `we3=1` during cycle N+1..N+2.
  - The register file captures at edge N+2.
- Throughput: one write per cycle sustained. A full queue has a one-cycle `req_ready` bubble after a pop.
- `pendN` is valid in the same cycle as `chk_aN` and reflects the state after the last edge.

## Structure
- Shared package `rv_pkg` holds `DATA_W`, `ADDR_W`, `REG_ZERO` (= 0) and the write-request typedef `{addr, data}`. These are reused by the register file.
- One sub-module, `rf_wq_fifo`:
  - Contains storage, pointers and count, with push/pop/flush inputs.
  - Exposes the per-entry valid/addr vectors for the pending compare.
- The top level holds the output registers, the x0 filter, `drop_cnt` and the pending logic.

## Test plan
- Reset, then push (3, 0xA5) with `drain_en=1` → `we3=1`, `wa3=3`, `wd3=0xA5` exactly two edges after acceptance. `pend` for 3 is 1 through the `we3` cycle, then 0.
- With `drain_en=0`, push four writes (1,0x11), (2,0x22), (1,0x33), (4,0x44):
  - `count=4` and `req_ready=0`; a fifth request is stalled.
  - Then raise `drain_en` → `we3` pulses 4 cycles in order 0x11, 0x22, 0x33, 0x44.
- Push to x0 three times → `count` stays 0, `drop_cnt=3`, `we3` never asserts. Push x0 300 times → `drop_cnt=255`.
- Queue holding 2 entries, assert `flush` together with `req_valid` → `count=0`, `we3=0` next cycle, the request is not accepted, `pend1=pend2=0`.
- Continuous push and pop at `count=2` for 10 cycles → `count` stays 2 and data comes out in FIFO order with the pointers wrapping.
- Pull `rst` low asynchronously while `we3=1` and `count=3` → all outputs drop to their reset values before the next clock edge.
